alu_cfg_sequencer: RTL

//  APB master that shares the ALU register block (regs at 0x10/0x14/0x18/0x1C) between
//  NUM_REQ on-chip requesters. Arbitrates round-robin, runs one APB transfer at a time
//  (SETUP -> ACCESS -> wait pready), returns read data or an error to the requester.

---
 rtl/alu_ctrl_pkg.sv | 13 +
 rtl/alu_cfg_sequencer_if.sv | 28 ++
 rtl/alu_rr_arbiter.sv | 28 ++
 rtl/alu_cfg_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state encoding and ALU register map for the config sequencer
package alu_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR, S_RESP} seq_state_e;
    localparam logic [31:0] ALU_REG1 = 32'h10;
    localparam logic [31:0] ALU_REG2 = 32'h14;
    localparam logic [31:0] ALU_REG3 = 32'h18;
    localparam logic [31:0] ALU_REG4 = 32'h1C;
    localparam logic [31:0] BASE_ADDR_DEF = ALU_REG1;
    localparam logic [31:0] LAST_ADDR_DEF = ALU_REG4;
    function automatic logic addr_ok(input logic [31:0] a, input logic [31:0] base, input logic [31:0] last);
        return a >= base && a <= last && a[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/alu_cfg_sequencer_if.sv
// alu_cfg_sequencer_if: requester, response and APB signals of the config sequencer
interface alu_cfg_sequencer_if #(parameter int NUM_REQ = 2);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: picks the first valid requester at or after ptr_i, wrapping around
module alu_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic hit;
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        hit     = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!hit && req_i[i] && (int'(ptr_i) + k) % N == i) begin
                    hit        = 1'b1;
                    grant_o[i] = 1'b1;
                    idx_o      = IW'(i);
                end
            end
        end
        any_o = hit;
    end
endmodule

// File: rtl/alu_cfg_sequencer.sv
// alu_cfg_sequencer: round-robin APB master sharing the ALU register block among requesters
module alu_cfg_sequencer import alu_ctrl_pkg::*; #(
    parameter int          NUM_REQ   = 2,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter logic [31:0] LAST_ADDR = LAST_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_cfg_sequencer_if.master   bus,
    output logic                  busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_e    st_q, st_d;
    logic [IW-1:0] rr_q, rr_d, id_q, id_d, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic          any, wr_q, wr_d, err_q, err_d, ok;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sel_addr;
    logic [CW-1:0] cnt_q, cnt_d;

    alu_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_i(bus.req_valid), .ptr_i(rr_q), .grant_o(gnt), .idx_o(gnt_idx), .any_o(any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        rr_d     = rr_q;
        id_d     = id_q;
        wr_d     = wr_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        sel_addr = bus.req_addr[32*gnt_idx +: 32];
        ok       = addr_ok(sel_addr, BASE_ADDR, LAST_ADDR);
        case (st_q)
            S_IDLE: if (any) begin
                id_d    = gnt_idx;
                rr_d    = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                rdata_d = '0;
                err_d   = !ok;
                cnt_d   = '0;
                st_d    = ok ? S_SETUP : S_ERR;
                // bus fields only move for transfers that will actually reach the slave
                if (ok) begin
                    wr_d    = bus.req_write[gnt_idx];
                    addr_d  = sel_addr;
                    wdata_d = bus.req_wdata[32*gnt_idx +: 32];
                end
            end
            S_SETUP: st_d = S_ACCESS;
            S_ACCESS: begin
                if (bus.pready) begin
                    rdata_d = wr_q ? '0 : bus.prdata;
                    st_d    = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    st_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR:  st_d = S_RESP;
            S_RESP: st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    assign bus.req_ready = (st_q == S_IDLE) ? gnt : '0;
    assign bus.psel      = (st_q == S_SETUP) || (st_q == S_ACCESS);
    assign bus.penable   = st_q == S_ACCESS;
    assign bus.pwrite    = wr_q;
    assign bus.paddr     = addr_q;
    assign bus.pwdata    = wdata_q;
    assign bus.rsp_valid = st_q == S_RESP;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = (st_q == S_RESP) && err_q;
    assign bus.rsp_rdata = (st_q == S_RESP) ? rdata_q : '0;
    assign busy          = st_q != S_IDLE;
endmodule
